adc_spi_responder: RTL



---
 rtl/adc_spi_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: cycle-based SPI responder model of an LTC2308-class
// 8-channel 12-bit ADC. It oversamples sclk/cs_n/din in the clk domain,
// captures the 6-bit config word, runs a timed conversion and shifts the
// selected result out on dout during the following frame.
// Optional feature macro: ADC_SPI_RESP_STATS_EN adds frame_count/err_count.
module adc_spi_responder #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int CFG_W       = 6,
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       din,
    output logic                       dout,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       busy,
    output logic                       cfg_valid,
    output logic [CFG_W-1:0]           cfg_word,
    output logic                       frame_err
`ifdef ADC_SPI_RESP_STATS_EN
    ,
    output logic [15:0]                frame_count,
    output logic [15:0]                err_count
`endif
);

    localparam int TMR_W = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FRAME   = 2'd1,
        CONVERT = 2'd2
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  din_sync;
    logic                    sclk_prev;
    logic                    cs_prev;
    logic [DATA_W-1:0]       result_r;
    logic [DATA_W-1:0]       shift_r;
    logic [CFG_W-1:0]        cfg_sr;
    logic [4:0]              bit_cnt;
    logic [TMR_W-1:0]        timer;

    logic sclk_s, cs_s, din_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Config bit map (MSB..LSB): S/D, O/S, S1, S0, UNI, SLP.
    function automatic logic [DATA_W-1:0] calc_result(
        input logic [CFG_W-1:0]         cfg,
        input logic [NUM_CH*DATA_W-1:0] data
    );
        logic [2:0]        ch_a;
        logic [2:0]        ch_b;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W:0]   d;
        logic [DATA_W-1:0] r;
        ch_a = {cfg[3], cfg[2], cfg[4]};
        ch_b = {cfg[3], cfg[2], ~cfg[4]};
        a    = data[ch_a*DATA_W +: DATA_W];
        b    = data[ch_b*DATA_W +: DATA_W];
        d    = {1'b0, a} - {1'b0, b};
        if (cfg[5]) begin
            // Single-ended: bipolar is offset binary flipped to two's complement.
            r = cfg[1] ? a : (a ^ {1'b1, {(DATA_W-1){1'b0}}});
        end else if (cfg[1]) begin
            // Differential unipolar clamps negative differences to zero.
            r = d[DATA_W] ? {DATA_W{1'b0}} : d[DATA_W-1:0];
        end else if (!d[DATA_W] && d[DATA_W-1]) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (d[DATA_W] && !d[DATA_W-1]) begin
            r = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = d[DATA_W-1:0];
        end
        return r;
    endfunction

    // Synchronise the asynchronous SPI lines and keep one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= {SYNC_STAGES{1'b0}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            din_sync  <= {SYNC_STAGES{1'b0}};
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // Frame / conversion state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result_r  <= {DATA_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
            cfg_sr    <= {CFG_W{1'b0}};
            bit_cnt   <= 5'd0;
            timer     <= {TMR_W{1'b0}};
            dout      <= 1'b0;
            busy      <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_word  <= {CFG_W{1'b0}};
            frame_err <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        shift_r <= result_r;
                        dout    <= result_r[DATA_W-1];
                        bit_cnt <= 5'd0;
                        state   <= FRAME;
                    end
                end
                FRAME: begin
                    if (cs_rise) begin
                        dout <= 1'b0;
                        if (bit_cnt >= 5'(CFG_W)) begin
                            cfg_word  <= cfg_sr;
                            cfg_valid <= 1'b1;
                            if (!cfg_sr[0]) begin
                                busy  <= 1'b1;
                                timer <= TMR_W'(CONV_CYCLES);
                                state <= CONVERT;
                            end else begin
                                result_r <= {DATA_W{1'b0}};
                                state    <= IDLE;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        if (bit_cnt < 5'(CFG_W)) begin
                            cfg_sr <= {cfg_sr[CFG_W-2:0], din_s};
                        end
                        if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (sclk_fall) begin
                        // Zero fill means dout naturally stays 0 after the last result bit.
                        shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                        dout    <= shift_r[DATA_W-2];
                    end
                end
                CONVERT: begin
                    // A frame opened during conversion is rejected; dout stays 0.
                    if (cs_fall) begin
                        frame_err <= 1'b1;
                    end
                    if (timer == {TMR_W{1'b0}}) begin
                        result_r <= calc_result(cfg_word, ch_data);
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADC_SPI_RESP_STATS_EN
    // Free-running wrap-around counters of accepted configs and protocol errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= 16'd0;
            err_count   <= 16'd0;
        end else begin
            if (cfg_valid) begin
                frame_count <= frame_count + 16'd1;
            end
            if (frame_err) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule
